// File: rtl/neopixel_frame_driver.sv
// neopixel_frame_driver
//   Drives a WS2812-class single-wire strand of NUM_PIXELS pixels, each with
//   CHANNELS colour bytes (3 = GRB, 4 = GRBW). Colour data is double-buffered.
//   The host writes the back buffer at any time. A send copies it into the
//   front buffer, and the front buffer is serialised with a global brightness
//   scale applied to each byte as it is sent.
//
// Ports
//   clock          system clock
//   reset          asynchronous, active-high; aborts any frame, clears buffers
//   color_level    channel intensity to load
//   color_index    channel select: 0=R, 1=B, 2=G, 3=W
//   pixel_index    target pixel for a load
//   load_color     write color_level into back[pixel_index][color_index]
//   send_it        request transmission of the back buffer
//   brightness     global scale, captured when send_it is accepted
//   neo_data       strand serial data (registered)
//   ready_to_load  back buffer writable (always 1)
//   ready_to_send  high only in IDLE
//   busy           frame bits or latch gap in progress
//   fsm_state      current state (IDLE=0, HIGH=1, LOW=2, LATCH=3) for debug
//
// Handshake: load_color is a one-cycle write strobe. ready_to_load is always
// high, so every strobe with a legal pixel and channel is taken at that edge.
// send_it is a request qualified by ready_to_send. It is accepted only on an
// edge where ready_to_send=1 (IDLE). A request raised while busy is dropped,
// not queued. If send_it stays high, a new frame starts on the first IDLE
// cycle.
module neopixel_frame_driver #(
  parameter int NUM_PIXELS   = 8,
  parameter int CHANNELS     = 3,
  parameter int T0H          = 18,
  parameter int T0L          = 40,
  parameter int T1H          = 35,
  parameter int T1L          = 30,
  parameter int RESET_CYCLES = 2500,
  parameter int IDX_W        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       color_level,
  input  logic [1:0]       color_index,
  input  logic [IDX_W-1:0] pixel_index,
  input  logic             load_color,
  input  logic             send_it,
  input  logic [7:0]       brightness,
  output logic             neo_data,
  output logic             ready_to_load,
  output logic             ready_to_send,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int TOTAL_BITS = NUM_PIXELS * CHANNELS * 8;
  localparam int MAX_H      = (T0H > T1H) ? T0H : T1H;
  localparam int MAX_L      = (T0L > T1L) ? T0L : T1L;
  localparam int MAX_HL     = (MAX_H > MAX_L) ? MAX_H : MAX_L;
  localparam int MAX_T      = (MAX_HL > RESET_CYCLES) ? MAX_HL : RESET_CYCLES;
  localparam int CYC_W      = $clog2(MAX_T + 1);
  localparam int BIT_W      = $clog2(TOTAL_BITS + 1);

  localparam logic [CYC_W-1:0] T0H_LAST   = CYC_W'(T0H - 1);
  localparam logic [CYC_W-1:0] T0L_LAST   = CYC_W'(T0L - 1);
  localparam logic [CYC_W-1:0] T1H_LAST   = CYC_W'(T1H - 1);
  localparam logic [CYC_W-1:0] T1L_LAST   = CYC_W'(T1L - 1);
  localparam logic [CYC_W-1:0] LATCH_LAST = CYC_W'(RESET_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(TOTAL_BITS - 1);
  localparam logic [1:0]       LAST_SLOT  = 2'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, LATCH = 2'd3} state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] pix_cnt;   // pixel being sent
  logic [1:0]       slot_cnt;  // wire slot within pixel: 0=G 1=R 2=B 3=W
  logic [2:0]       bpos;      // bit within byte, 0 = MSB
  logic [7:0]       brightness_q;

  logic [7:0] back_buf  [NUM_PIXELS][4];
  logic [7:0] front_buf [NUM_PIXELS][4];
  logic [7:0] back_next [NUM_PIXELS][4];

  logic             write_ok;
  logic [1:0]       cur_chan;
  logic [7:0]       cur_level;
  logic [15:0]      product;
  logic [7:0]       scaled;
  logic             cur_bit;
  logic [CYC_W-1:0] high_last;
  logic [CYC_W-1:0] low_last;
  logic             last_bit;

  // W writes are dropped on a 3-channel strand so the unused slot stays zero.
  assign write_ok = load_color && (32'(pixel_index) < NUM_PIXELS) &&
                    !((color_index == 2'd3) && (CHANNELS == 3));

  // The back buffer including this cycle's write. A send accepted on the
  // same edge copies this merged view, so a simultaneous load is not lost.
  always_comb begin
    back_next = back_buf;
    if (write_ok) back_next[pixel_index][color_index] = color_level;
  end

  // Wire order G,R,B,W maps onto the storage indices 2,0,1,3.
  always_comb begin
    case (slot_cnt)
      2'd0:    cur_chan = 2'd2;
      2'd1:    cur_chan = 2'd0;
      2'd2:    cur_chan = 2'd1;
      default: cur_chan = 2'd3;
    endcase
  end

  assign cur_level = front_buf[pix_cnt][cur_chan];
  assign product   = {8'd0, cur_level} * ({8'd0, brightness_q} + 16'd1);
  assign scaled    = 8'(product >> 8);
  assign cur_bit   = scaled[3'd7 - bpos];
  assign high_last = cur_bit ? T1H_LAST : T0H_LAST;
  assign low_last  = cur_bit ? T1L_LAST : T0L_LAST;
  assign last_bit  = (bit_cnt == LAST_BIT);

  assign ready_to_load = 1'b1;
  assign ready_to_send = (state == IDLE);
  assign busy          = (state != IDLE);
  assign fsm_state     = state;

  // neo_data is written on the edge that ends each state cycle. The wire
  // therefore trails the state by one cycle. A send accepted at edge k goes
  // high after edge k+1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      neo_data     <= 1'b0;
      cyc_cnt      <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      slot_cnt     <= '0;
      bpos         <= '0;
      brightness_q <= '0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 4; c++) begin
          back_buf[p][c]  <= '0;
          front_buf[p][c] <= '0;
        end
      end
    end else begin
      back_buf <= back_next;
      case (state)
        IDLE: begin
          neo_data <= 1'b0;
          if (send_it) begin
            front_buf    <= back_next;
            brightness_q <= brightness;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            slot_cnt     <= '0;
            bpos         <= '0;
            cyc_cnt      <= '0;
            state        <= HIGH;
          end
        end
        HIGH: begin
          neo_data <= 1'b1;
          if (cyc_cnt == high_last) begin
            cyc_cnt <= '0;
            state   <= LOW;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        LOW: begin
          neo_data <= 1'b0;
          if (cyc_cnt == low_last) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (last_bit) begin
              state <= LATCH;
            end else begin
              state <= HIGH;
              if (bpos == 3'd7) begin
                bpos <= '0;
                if (slot_cnt == LAST_SLOT) begin
                  slot_cnt <= '0;
                  pix_cnt  <= pix_cnt + IDX_W'(1);
                end else begin
                  slot_cnt <= slot_cnt + 2'd1;
                end
              end else begin
                bpos <= bpos + 3'd1;
              end
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        LATCH: begin
          neo_data <= 1'b0;
          if (cyc_cnt == LATCH_LAST) begin
            cyc_cnt <= '0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        default: begin
          neo_data <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
